// File: rtl/keypad_emu.sv
// Keypad press emulator: closes one row/column contact of a 4x4 matrix
// with contact chatter at press and release, timed in prescaled ticks.
// Ports: clk, rst (sync, active-high)
//   cmd_valid/cmd_ready/cmd_key/cmd_hold : press command handshake
//   abort : cancel press in progress
//   col (in, active-low scan) -> row (out, active-low sense)
//   busy : not idle, done : one-cycle completion pulse
module keypad_emu #(
  parameter int TICK_DIV     = 50000,
  parameter int BOUNCE_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        cmd_ready,
  input  logic        abort,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done
);

  localparam int PSW = $clog2(TICK_DIV);
  localparam int PHW =
    (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
  localparam int PH_LAST_I =
    (BOUNCE_TICKS > 0) ? BOUNCE_TICKS - 1 : 0;
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(PH_LAST_I);
  localparam bit NO_BOUNCE = (BOUNCE_TICKS == 0);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic            contact, contact_n;
  logic [PSW-1:0]  presc, presc_n;
  logic [PHW-1:0]  phase, phase_n;
  logic [15:0]     hold_cnt, hold_cnt_n;
  logic [15:0]     hold_lat, hold_lat_n;
  logic [3:0]      key, key_n;
  logic            tick;

  assign tick = (presc == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      contact  <= 1'b0;
      presc    <= '0;
      phase    <= '0;
      hold_cnt <= '0;
      hold_lat <= '0;
      key      <= '0;
    end else begin
      state    <= state_n;
      contact  <= contact_n;
      presc    <= presc_n;
      phase    <= phase_n;
      hold_cnt <= hold_cnt_n;
      hold_lat <= hold_lat_n;
      key      <= key_n;
    end
  end

  always_comb begin
    state_n    = state;
    contact_n  = contact;
    phase_n    = phase;
    hold_cnt_n = hold_cnt;
    hold_lat_n = hold_lat;
    key_n      = key;
    // prescaler runs only while a press is active
    if (state == IDLE) begin
      presc_n = '0;
    end else if (tick) begin
      presc_n = '0;
    end else begin
      presc_n = presc + 1'b1;
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          key_n      = cmd_key;
          hold_lat_n = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
          presc_n    = '0;
          phase_n    = '0;
          hold_cnt_n = '0;
          contact_n  = 1'b1;
          state_n    = NO_BOUNCE ? HOLD : BOUNCE_IN;
        end
      end
      BOUNCE_IN: begin
        if (tick) begin
          if (phase == PH_LAST) begin
            contact_n  = 1'b1;
            phase_n    = '0;
            hold_cnt_n = '0;
            state_n    = HOLD;
          end else begin
            contact_n = ~contact;
            phase_n   = phase + 1'b1;
          end
        end
      end
      HOLD: begin
        contact_n = 1'b1;
        if (tick) begin
          // hold_lat is never 0, so the minus one cannot underflow
          if (hold_cnt == hold_lat - 16'd1) begin
            contact_n = 1'b0;
            phase_n   = '0;
            state_n   = NO_BOUNCE ? DONE : BOUNCE_OUT;
          end else begin
            hold_cnt_n = hold_cnt + 16'd1;
          end
        end
      end
      BOUNCE_OUT: begin
        if (tick) begin
          if (phase == PH_LAST) begin
            contact_n = 1'b0;
            phase_n   = '0;
            state_n   = DONE;
          end else begin
            contact_n = ~contact;
            phase_n   = phase + 1'b1;
          end
        end
      end
      DONE: begin
        contact_n = 1'b0;
        state_n   = IDLE;
      end
      default: begin
        contact_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    // done is decoded from state, so aborting in DONE keeps its pulse
    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      contact_n = 1'b0;
      presc_n   = '0;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // only the latched row/column pair is sensed
  always_comb begin
    row = 4'hF;
    if (contact && !col[key[1:0]]) begin
      row[key[3:2]] = 1'b0;
    end
  end

endmodule
